// File: rtl/maze_walker_if.sv
// Step-channel bundle for maze_walker: action offer, reward-ROM lookup and step-record handoff.
// Signal names are seen from the walker's side; the slave modport is the walker and master is its environment.
interface maze_walker_if #(
    parameter int ROW_W      = 3,
    parameter int COL_W      = 3,
    parameter int ACT_W      = 2,
    parameter int DATA_WIDTH = 8
);
    logic                         i_act_valid;
    logic                         o_act_ready;
    logic [ACT_W-1:0]             i_action;
    logic [ROW_W+COL_W+ACT_W-1:0] o_rt_addr;
    logic                         o_rt_read;
    logic [DATA_WIDTH-1:0]        i_rt_data;
    logic                         o_step_valid;
    logic                         i_step_ready;
    logic [ROW_W+COL_W-1:0]       o_state;
    logic [ACT_W-1:0]             o_action;
    logic [DATA_WIDTH-1:0]        o_reward;
    logic [ROW_W+COL_W-1:0]       o_next_state;
    logic                         o_done;
    logic                         o_timeout;

    modport slave (
        input  i_act_valid, i_action, i_rt_data, i_step_ready,
        output o_act_ready, o_rt_addr, o_rt_read, o_step_valid,
               o_state, o_action, o_reward, o_next_state, o_done, o_timeout
    );

    modport master (
        output i_act_valid, i_action, i_rt_data, i_step_ready,
        input  o_act_ready, o_rt_addr, o_rt_read, o_step_valid,
               o_state, o_action, o_reward, o_next_state, o_done, o_timeout
    );
endinterface

// File: rtl/maze_walker.sv
// Grid-world environment stepper: looks up the reward for (state, action) and emits an (s, a, r, s', done) record.
// Optional episode step limit is built when WALKER_STEP_LIMIT_EN is defined.
module maze_walker #(
    parameter int ROW_W      = 3,
    parameter int COL_W      = 3,
    parameter int ACT_W      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int START_ROW  = 0,
    parameter int START_COL  = 0,
    parameter int GOAL_ROW   = 7,
    parameter int GOAL_COL   = 7,
    parameter int RD_LAT     = 1,
    parameter int MAX_STEPS  = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    maze_walker_if.slave bus
);
    localparam logic [ACT_W-1:0] ACT_LEFT  = ACT_W'(0);
    localparam logic [ACT_W-1:0] ACT_UP    = ACT_W'(1);
    localparam logic [ACT_W-1:0] ACT_RIGHT = ACT_W'(2);
    localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] ROW_GOAL  = ROW_W'(GOAL_ROW);
    localparam logic [COL_W-1:0] COL_GOAL  = COL_W'(GOAL_COL);
    localparam logic [ROW_W-1:0] ROW_MAX   = '1;
    localparam logic [COL_W-1:0] COL_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_OUT} state_t;

    state_t                       state, state_nxt;
    logic [ROW_W-1:0]             cur_row, next_row_q, mv_row;
    logic [COL_W-1:0]             cur_col, next_col_q, mv_col;
    logic [ACT_W-1:0]             act_q;
    logic [ROW_W+COL_W+ACT_W-1:0] addr_q;
    logic [1:0]                   lat_cnt;
    logic [DATA_WIDTH-1:0]        reward_q;
    logic                         done_q;
    logic                         mv_goal;
    logic                         limit_hit;
    logic                         capture;
    logic                         handshake;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.i_act_valid)  state_nxt = S_READ;
            S_READ:                        state_nxt = S_WAIT;
            S_WAIT:  if (lat_cnt == '0)    state_nxt = S_OUT;
            S_OUT:   if (bus.i_step_ready) state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    assign capture   = (state == S_WAIT) && (lat_cnt == '0);
    assign handshake = (state == S_OUT) && bus.i_step_ready;

    // Moves that would leave the grid are clamped so the agent stays put.
    always_comb begin
        mv_row = cur_row;
        mv_col = cur_col;
        case (act_q)
            ACT_LEFT:  if (cur_col != '0)     mv_col = cur_col - 1'b1;
            ACT_UP:    if (cur_row != '0)     mv_row = cur_row - 1'b1;
            ACT_RIGHT: if (cur_col != COL_MAX) mv_col = cur_col + 1'b1;
            default:   if (cur_row != ROW_MAX) mv_row = cur_row + 1'b1;
        endcase
        mv_goal = (mv_row == ROW_GOAL) && (mv_col == COL_GOAL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cur_row    <= ROW_START;
            cur_col    <= COL_START;
            act_q      <= '0;
            addr_q     <= '0;
            lat_cnt    <= '0;
            reward_q   <= '0;
            next_row_q <= '0;
            next_col_q <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.i_act_valid) begin
                    act_q  <= bus.i_action;
                    addr_q <= {cur_row, cur_col, bus.i_action};
                end
                S_READ: lat_cnt <= 2'(RD_LAT - 1);
                S_WAIT: if (capture) begin
                    reward_q   <= bus.i_rt_data;
                    next_row_q <= mv_row;
                    next_col_q <= mv_col;
                    done_q     <= mv_goal | limit_hit;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
                S_OUT: if (bus.i_step_ready) begin
                    if (done_q) begin
                        cur_row <= ROW_START;
                        cur_col <= COL_START;
                    end else begin
                        cur_row <= next_row_q;
                        cur_col <= next_col_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WALKER_STEP_LIMIT_EN
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    logic [STEP_W-1:0] step_cnt;
    logic              timeout_q;

    // A goal on the last allowed step is reported as a normal finish, not a timeout.
    assign limit_hit = (step_cnt == STEP_W'(MAX_STEPS - 1)) && !mv_goal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (capture)   timeout_q <= limit_hit;
            if (handshake) step_cnt  <= done_q ? '0 : step_cnt + 1'b1;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    assign limit_hit     = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_act_ready  = (state == S_IDLE);
    assign bus.o_rt_read    = (state == S_READ);
    assign bus.o_step_valid = (state == S_OUT);
    assign bus.o_rt_addr    = addr_q;
    assign bus.o_state      = {cur_row, cur_col};
    assign bus.o_action     = act_q;
    assign bus.o_reward     = reward_q;
    assign bus.o_next_state = {next_row_q, next_col_q};
    assign bus.o_done       = done_q;
endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: directed walks plus random actions against a grid-arithmetic model.
// A small rtable model returns rewards one clock after the read strobe and junk on every other cycle.
module tb_maze_walker;
    localparam int ROW_W      = 3;
    localparam int COL_W      = 3;
    localparam int ACT_W      = 2;
    localparam int DATA_WIDTH = 8;
    localparam int RD_LAT     = 1;
    localparam int ROWS       = 1 << ROW_W;
    localparam int COLS       = 1 << COL_W;
    localparam int GOAL_ROW   = 7;
    localparam int GOAL_COL   = 7;
    localparam int ADDR_N     = 1 << (ROW_W + COL_W + ACT_W);
`ifdef WALKER_STEP_LIMIT_EN
    localparam int MAX_STEPS  = 4;
    localparam bit LIMIT_EN   = 1'b1;
`else
    localparam int MAX_STEPS  = 64;
    localparam bit LIMIT_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    maze_walker_if #(.ROW_W(ROW_W), .COL_W(COL_W), .ACT_W(ACT_W), .DATA_WIDTH(DATA_WIDTH)) bus ();

    maze_walker #(
        .ROW_W(ROW_W), .COL_W(COL_W), .ACT_W(ACT_W), .DATA_WIDTH(DATA_WIDTH),
        .START_ROW(0), .START_COL(0), .GOAL_ROW(GOAL_ROW), .GOAL_COL(GOAL_COL),
        .RD_LAT(RD_LAT), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] reward_mem [0:ADDR_N-1];

    always @(posedge clk)
        bus.i_rt_data <= bus.o_rt_read ? reward_mem[bus.o_rt_addr] : DATA_WIDTH'($urandom);

    int checks   = 0;
    int failures = 0;
    int ref_row, ref_col, ep_steps;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one action, follow it through the lookup, hold the record for 'hold' cycles, then accept it.
    task automatic applyStimulus(input int act, input int hold);
        int nr, nc, lat, exp_addr, exp_state, exp_next;
        bit goal, lim;
        logic [DATA_WIDTH-1:0] exp_rew;
        nr = ref_row;
        nc = ref_col;
        case (act)
            0:       nc = (ref_col > 0)        ? ref_col - 1 : ref_col;
            1:       nr = (ref_row > 0)        ? ref_row - 1 : ref_row;
            2:       nc = (ref_col < COLS - 1) ? ref_col + 1 : ref_col;
            default: nr = (ref_row < ROWS - 1) ? ref_row + 1 : ref_row;
        endcase
        goal      = (nr == GOAL_ROW) && (nc == GOAL_COL);
        lim       = LIMIT_EN && (ep_steps == MAX_STEPS - 1);
        exp_state = ref_row * COLS + ref_col;
        exp_next  = nr * COLS + nc;
        exp_addr  = exp_state * (1 << ACT_W) + act;
        exp_rew   = reward_mem[exp_addr];

        checkOutput("act_ready_idle", 32'(bus.o_act_ready), 32'd1);
        bus.i_act_valid = 1'b1;
        bus.i_action    = ACT_W'(act);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.i_act_valid = 1'b0;
        bus.i_action    = ACT_W'($urandom);
        checkOutput("rt_read_pulse", 32'(bus.o_rt_read), 32'd1);
        checkOutput("rt_addr", 32'(bus.o_rt_addr), 32'(exp_addr));
        checkOutput("act_ready_busy", 32'(bus.o_act_ready), 32'd0);
        while (bus.o_step_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.o_step_valid !== 1'b1) begin
                checkOutput("rt_read_single", 32'(bus.o_rt_read), 32'd0);
                checkOutput("rt_addr_hold", 32'(bus.o_rt_addr), 32'(exp_addr));
            end
        end
        // lat counts the accepting edge as the first one
        checkOutput("accept_to_valid", 32'(lat), 32'(RD_LAT + 2));

        for (int h = 0; h <= hold; h++) begin
            checkOutput("step_valid", 32'(bus.o_step_valid), 32'd1);
            checkOutput("act_ready_out", 32'(bus.o_act_ready), 32'd0);
            checkOutput("rec_state", 32'(bus.o_state), 32'(exp_state));
            checkOutput("rec_action", 32'(bus.o_action), 32'(act));
            checkOutput("rec_reward", 32'(bus.o_reward), 32'(exp_rew));
            checkOutput("rec_next", 32'(bus.o_next_state), 32'(exp_next));
            checkOutput("rec_done", 32'(bus.o_done), 32'(goal || lim));
            checkOutput("rec_timeout", 32'(bus.o_timeout), 32'(lim && !goal));
            if (h < hold) begin
                bus.i_act_valid  = 1'b1;
                bus.i_action     = ACT_W'($urandom);
                bus.i_step_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.i_step_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_step_ready = 1'b0;
        bus.i_act_valid  = 1'b0;
        checkOutput("valid_drop", 32'(bus.o_step_valid), 32'd0);
        checkOutput("act_ready_after", 32'(bus.o_act_ready), 32'd1);

        if (goal || lim) begin
            ref_row  = 0;
            ref_col  = 0;
            ep_steps = 0;
        end else begin
            ref_row  = nr;
            ref_col  = nc;
            ep_steps = ep_steps + 1;
        end
    endtask

    task automatic abortStep(input int act);
        bus.i_act_valid = 1'b1;
        bus.i_action    = ACT_W'(act);
        @(posedge clk);
        @(negedge clk);
        bus.i_act_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_wait", 32'(bus.o_step_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_valid", 32'(bus.o_step_valid), 32'd0);
        checkOutput("abort_ready", 32'(bus.o_act_ready), 32'd1);
        checkOutput("abort_state", 32'(bus.o_state), 32'd0);
        checkOutput("abort_addr", 32'(bus.o_rt_addr), 32'd0);
        checkOutput("abort_reward", 32'(bus.o_reward), 32'd0);
        checkOutput("abort_done", 32'(bus.o_done), 32'd0);
        ref_row  = 0;
        ref_col  = 0;
        ep_steps = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abort_no_record", 32'(bus.o_step_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.i_act_valid  = 1'b0;
        bus.i_action     = '0;
        bus.i_step_ready = 1'b0;
        for (int i = 0; i < ADDR_N; i++) reward_mem[i] = DATA_WIDTH'($urandom);
        reward_mem[8'h02] = 8'h00;
        reward_mem[8'hDF] = 8'hFF;
        ref_row  = 0;
        ref_col  = 0;
        ep_steps = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_act_ready", 32'(bus.o_act_ready), 32'd1);
        checkOutput("rst_valid", 32'(bus.o_step_valid), 32'd0);
        checkOutput("rst_rt_read", 32'(bus.o_rt_read), 32'd0);
        checkOutput("rst_addr", 32'(bus.o_rt_addr), 32'd0);
        checkOutput("rst_state", 32'(bus.o_state), 32'd0);
        checkOutput("rst_next", 32'(bus.o_next_state), 32'd0);
        checkOutput("rst_done", 32'(bus.o_done), 32'd0);
        checkOutput("rst_timeout", 32'(bus.o_timeout), 32'd0);

        $display("[TB] directed moves from the start corner");
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(3, 0);
        for (int i = 0; i < 5; i++) applyStimulus(3, 0);
        for (int i = 0; i < 6; i++) applyStimulus(2, 0);

        $display("[TB] goal step under backpressure");
        applyStimulus(3, 5);
        applyStimulus(0, 0);

        $display("[TB] clamping at the grid edges");
        for (int i = 0; i < 8; i++) applyStimulus(3, 0);
        applyStimulus(0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(2, 0);

        $display("[TB] reset during lookup");
        abortStep(3);
        for (int i = 0; i < 4; i++) applyStimulus(2, 0);

        $display("[TB] random walk");
        for (int i = 0; i < 40; i++) applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maze_walker.md
Name: maze_walker

Overview:
- Environment-stepping stage placed directly upstream of the reward ROM (rtable).
- Holds the agent's current grid state (row, col).
- Accepts one action per step, forms the {row, col, action} ROM address and captures the returned reward.
- Computes the wall-clamped next state, flags goal arrival, and hands a complete (s, a, r, s', done) step record to the downstream Q-update stage via valid/ready.

Parameters:
- ROW_W, 3, row index width; grid has 2^ROW_W rows
- COL_W, 3, column index width; grid has 2^COL_W columns
- ACT_W, 2, action width; fixed encoding 00 left, 01 up, 10 right, 11 down
- DATA_WIDTH, 8, reward width; must match rtable
- START_ROW, 0, episode start row
- START_COL, 0, episode start column
- GOAL_ROW, 7, goal row
- GOAL_COL, 7, goal column
- RD_LAT, 1, rtable read latency in clocks (1..4)
- MAX_STEPS, 64, episode step limit; used only with the optional feature

Ports:
- i_clk  in  1  clock; all logic on posedge
- i_rst  in  1  synchronous, active-high reset
- i_act_valid  in  1  action offered
- o_act_ready  out  1  walker can accept an action
- i_action  in  ACT_W  action code
- o_rt_addr  out  ROW_W+COL_W+ACT_W  rtable address {row, col, action}
- o_rt_read  out  1  rtable read strobe
- i_rt_data  in  DATA_WIDTH  rtable reward
- o_step_valid  out  1  step record valid
- i_step_ready  in  1  downstream accepts record
- o_state  out  ROW_W+COL_W  {row, col} before the move
- o_action  out  ACT_W  action taken
- o_reward  out  DATA_WIDTH  raw reward from rtable, passed through unmodified
- o_next_state  out  ROW_W+COL_W  {row, col} after the move
- o_done  out  1  episode ended on this step
- o_timeout  out  1  episode ended by step limit (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values:
  - FSM in IDLE; current state = {START_ROW, START_COL}
  - o_act_ready=1 (Moore output of IDLE); all other outputs 0; step counter 0
- FSM states: IDLE, READ, WAIT, OUT.
- IDLE:
  - o_act_ready=1.
  - On i_act_valid&o_act_ready, register i_action and o_rt_addr={row, col, i_action}, then go to READ.
- READ:
  - o_rt_read=1 for exactly one cycle; o_rt_addr is held stable.
  - Load the latency counter with RD_LAT-1, then go to WAIT.
- WAIT:
  - Decrement the counter.
  - When it reaches 0, capture i_rt_data into o_reward and compute the next state in the same cycle, then go to OUT.
  - With RD_LAT=1, capture happens in the first WAIT cycle.
- Accept-to-valid latency: o_step_valid rises RD_LAT+2 cycles after the accepting edge (3 at default).
- Next-state rules:
  - left: col-1, clamped at col 0.
  - up: row-1, clamped at row 0.
  - right: col+1, clamped at col max.
  - down: row+1, clamped at row max.
  - A clamped move leaves the state unchanged; no arithmetic wrap-around ever occurs.
- Goal: o_done=1 iff next state == {GOAL_ROW, GOAL_COL}. An action taken while already at the goal is still processed normally.
- OUT:
  - o_step_valid=1; all record outputs are held stable until i_step_ready.
  - On the handshake edge: if o_done, current state := start and step counter := 0; else current state := o_next_state. Then go to IDLE.
  - o_step_valid deasserts the cycle after the handshake.
- Throughput: at most one step per RD_LAT+3 cycles; a new action is never accepted while a step is in flight.
- i_action and i_rt_data are ignored outside their capture cycles.
- Reset mid-operation (any state): the in-flight step is discarded, no record is emitted, and all reset values are restored on the next edge.

Optional Feature:
- Macro: WALKER_STEP_LIMIT_EN.
- When defined:
  - An episode step counter increments on each OUT handshake.
  - When a step completes with counter == MAX_STEPS-1 and no goal, that record carries o_done=1 and o_timeout=1; state returns to start and the counter clears.
  - If the goal is reached on that same step, o_done=1 and o_timeout=0.
- When undefined: no counter logic is built, o_timeout is tied 0, and episodes end only at the goal.

Test Plan:
- Reset, then action 01 (up) at (0,0): o_rt_addr=8'h01, o_rt_read pulses 1 cycle; o_step_valid exactly 3 cycles after accept; o_reward = rtable output, o_next_state=(0,0), o_done=0.
- From (0,0), action 10 (right): addr 8'h02, reward 8'h00, next (0,1); after handshake, action 11 (down) gives addr 8'b000_001_11, next (1,1).
- Drive agent to (6,7), action 11: addr 8'hDF, reward 8'hFF, next (7,7), o_done=1; after handshake the next accepted action's address uses state (0,0).
- Backpressure: hold i_step_ready=0 for 5 cycles in OUT → all outputs stable, o_act_ready=0, offered actions not taken; raise ready → one handshake, o_act_ready=1 the following cycle.
- Assert i_rst during WAIT → next cycle o_step_valid=0, o_act_ready=1, state (0,0); no record ever emitted for the aborted step.
- With WALKER_STEP_LIMIT_EN and MAX_STEPS=4: four right moves from (0,0) → the 4th record shows next state (0,4), o_done=1, o_timeout=1, and the state resets to (0,0).
